// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/bubble/flush control
// Optional saturating stall-cycle counter built when PIPE_STALL_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int PAYLOAD_W       = 32,
  parameter int ADDR_W          = 5,
  parameter int STALL_W         = 6,
  parameter int STAGE           = 2,
  parameter bit CLEAR_ON_BUBBLE = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 wr_en,
  input  logic                 valid,
  input  logic                 in_delay_slot,
  input  logic                 next_in_delay_slot,
  input  logic [STALL_W-1:0]   stall_en,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [PAYLOAD_W-1:0] pipe_payload,
  output logic [ADDR_W-1:0]    pipe_wr_addr,
  output logic                 pipe_wr_en,
  output logic                 pipe_valid,
  output logic                 pipe_in_delay_slot,
  output logic                 pipe_next_in_delay_slot,
  output logic                 pipe_bubble,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic s_up;
  logic s_dn;
  logic kill;
  logic unused_stall_bits;

  generate
    if (STAGE >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must be below STALL_W");
    end
    // The last stage has no downstream stall bit, so it can never hold.
    if (STAGE < STALL_W - 1) begin : g_has_dn
      assign s_dn = stall_en[STAGE+1];
    end else begin : g_no_dn
      assign s_dn = 1'b0;
    end
  endgenerate

  assign s_up              = stall_en[STAGE];
  assign kill              = flush | (s_up & ~s_dn);
  assign unused_stall_bits = ^stall_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_payload            <= '0;
      pipe_wr_addr            <= '0;
      pipe_wr_en              <= 1'b0;
      pipe_valid              <= 1'b0;
      pipe_in_delay_slot      <= 1'b0;
      pipe_next_in_delay_slot <= 1'b0;
      pipe_bubble             <= 1'b0;
    end else if (kill) begin
      if (CLEAR_ON_BUBBLE) begin
        pipe_payload <= '0;
        pipe_wr_addr <= '0;
      end
      pipe_wr_en              <= 1'b0;
      pipe_valid              <= 1'b0;
      pipe_in_delay_slot      <= 1'b0;
      pipe_next_in_delay_slot <= 1'b0;
      pipe_bubble             <= 1'b1;
    end else if (!s_up) begin
      pipe_payload            <= payload;
      pipe_wr_addr            <= wr_addr;
      pipe_wr_en              <= wr_en & valid;
      pipe_valid              <= valid;
      pipe_in_delay_slot      <= in_delay_slot;
      pipe_next_in_delay_slot <= next_in_delay_slot;
      pipe_bubble             <= 1'b0;
    end else begin
      pipe_bubble <= 1'b0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (!flush && s_up && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (STAGE=2, CNT_W=4)
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] payload;
  logic [4:0]  wr_addr;
  logic        wr_en, valid, in_delay_slot, next_in_delay_slot;
  logic [5:0]  stall_en;
  logic        flush, cnt_clr;
  logic [31:0] pipe_payload;
  logic [4:0]  pipe_wr_addr;
  logic        pipe_wr_en, pipe_valid, pipe_in_delay_slot, pipe_next_in_delay_slot, pipe_bubble;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 0;

`ifdef PIPE_STALL_CNT_EN
  localparam int CNT_MAX = 15;
`else
  localparam int CNT_MAX = 0;
`endif

  pipe_stage_reg #(.PAYLOAD_W(32), .ADDR_W(5), .STALL_W(6), .STAGE(2),
                   .CLEAR_ON_BUBBLE(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .payload(payload), .wr_addr(wr_addr), .wr_en(wr_en),
    .valid(valid), .in_delay_slot(in_delay_slot), .next_in_delay_slot(next_in_delay_slot),
    .stall_en(stall_en), .flush(flush), .cnt_clr(cnt_clr),
    .pipe_payload(pipe_payload), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_en(pipe_wr_en),
    .pipe_valid(pipe_valid), .pipe_in_delay_slot(pipe_in_delay_slot),
    .pipe_next_in_delay_slot(pipe_next_in_delay_slot), .pipe_bubble(pipe_bubble),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs, advanced from the priority rules on every rising edge.
  logic [31:0] m_payload;
  logic [4:0]  m_addr;
  logic        m_we, m_valid, m_ids, m_nids, m_bub;
  int          m_cnt;

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      m_payload = 0; m_addr = 0; m_we = 0; m_valid = 0; m_ids = 0; m_nids = 0; m_bub = 0;
      m_cnt = 0;
    end else begin
      if (CNT_MAX != 0) begin
        if (cnt_clr) m_cnt = 0;
        else if (!flush && stall_en[2]) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
      if (flush || (stall_en[2] && !stall_en[3])) begin
        m_payload = 0; m_addr = 0; m_we = 0; m_valid = 0; m_ids = 0; m_nids = 0; m_bub = 1;
      end else if (!stall_en[2]) begin
        m_payload = payload; m_addr = wr_addr; m_we = wr_en && valid; m_valid = valid;
        m_ids = in_delay_slot; m_nids = next_in_delay_slot; m_bub = 0;
      end else begin
        m_bub = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("m_payload", 64'(pipe_payload), 64'(m_payload));
      check("m_wr_addr", 64'(pipe_wr_addr), 64'(m_addr));
      check("m_wr_en", 64'(pipe_wr_en), 64'(m_we));
      check("m_valid", 64'(pipe_valid), 64'(m_valid));
      check("m_ids", 64'(pipe_in_delay_slot), 64'(m_ids));
      check("m_nids", 64'(pipe_next_in_delay_slot), 64'(m_nids));
      check("m_bubble", 64'(pipe_bubble), 64'(m_bub));
      check("m_cnt", 64'(stall_cnt), 64'(m_cnt));
    end
  end

  // Apply one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic cyc(input logic rst, input logic [31:0] pl, input logic [4:0] ad,
                     input logic we, input logic vl, input logic ids, input logic nids,
                     input logic [5:0] st, input logic fl, input logic clr);
    reset = rst; payload = pl; wr_addr = ad; wr_en = we; valid = vl;
    in_delay_slot = ids; next_in_delay_slot = nids; stall_en = st; flush = fl; cnt_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 32'hDEADBEEF, 5'd7, 1, 1, 1, 1, 6'b000000, 0, 0);
    cyc(0, 32'hDEADBEEF, 5'd7, 1, 1, 1, 1, 6'b000100, 1, 0);
    check("rst_payload", 64'(pipe_payload), 64'h0);
    check("rst_valid", 64'(pipe_valid), 64'h0);
    check("rst_cnt", 64'(stall_cnt), 64'h0);

    cyc(1, 32'hDEADBEEF, 5'd7, 1, 1, 0, 0, 6'b000000, 0, 0);
    check("load_payload", 64'(pipe_payload), 64'hDEADBEEF);
    check("load_addr", 64'(pipe_wr_addr), 64'd7);
    check("load_wr_en", 64'(pipe_wr_en), 64'd1);
    check("load_valid", 64'(pipe_valid), 64'd1);

    cyc(1, 32'h11111111, 5'd3, 1, 1, 1, 0, 6'b000000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h22222222, 5'd9, 0, 1, 0, 1, 6'b001100, 0, 0);
      check("hold_payload", 64'(pipe_payload), 64'h11111111);
      check("hold_bubble", 64'(pipe_bubble), 64'd0);
      check("hold_ids", 64'(pipe_in_delay_slot), 64'd1);
    end
    cyc(1, 32'h22222222, 5'd9, 0, 1, 0, 1, 6'b000000, 0, 0);
    check("unhold_payload", 64'(pipe_payload), 64'h22222222);
    check("unhold_nids", 64'(pipe_next_in_delay_slot), 64'd1);

    cyc(1, 32'h33333333, 5'd4, 1, 1, 0, 0, 6'b000100, 0, 0);
    check("bubble_wr_en", 64'(pipe_wr_en), 64'd0);
    check("bubble_valid", 64'(pipe_valid), 64'd0);
    check("bubble_flag", 64'(pipe_bubble), 64'd1);
    check("bubble_payload", 64'(pipe_payload), 64'h0);
    cyc(1, 32'h33333333, 5'd4, 1, 1, 0, 0, 6'b000100, 0, 0);
    check("bubble2_payload", 64'(pipe_payload), 64'h0);
    check("bubble2_flag", 64'(pipe_bubble), 64'd1);

    cyc(1, 32'h44444444, 5'd12, 1, 1, 0, 0, 6'b000000, 0, 0);
    cyc(1, 32'h55555555, 5'd13, 1, 1, 0, 0, 6'b001100, 1, 0);
    check("flush_valid", 64'(pipe_valid), 64'd0);
    check("flush_bubble", 64'(pipe_bubble), 64'd1);
    check("flush_addr", 64'(pipe_wr_addr), 64'd0);

    cyc(1, 32'h66666666, 5'd21, 1, 0, 0, 1, 6'b000000, 0, 0);
    check("gate_wr_en", 64'(pipe_wr_en), 64'd0);
    check("gate_nids", 64'(pipe_next_in_delay_slot), 64'd1);
    check("gate_payload", 64'(pipe_payload), 64'h66666666);

    // Stall bits of other stages must not affect this boundary.
    cyc(1, 32'h77777777, 5'd22, 1, 1, 0, 0, 6'b110011, 0, 0);
    check("other_bits_payload", 64'(pipe_payload), 64'h77777777);

    cyc(1, 32'h0, 5'd0, 0, 0, 0, 0, 6'b000000, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 32'h88888888, 5'd1, 1, 1, 0, 0, 6'b001100, 0, 0);
    check("cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
    check("cnt_hold_payload", 64'(pipe_payload), 64'h0);
    cyc(1, 32'h88888888, 5'd1, 1, 1, 0, 0, 6'b001100, 0, 1);
    check("cnt_clr", 64'(stall_cnt), 64'h0);
    cyc(1, 32'h88888888, 5'd1, 1, 1, 0, 0, 6'b001100, 0, 0);
    check("cnt_restart", 64'(stall_cnt), 64'(CNT_MAX == 0 ? 0 : 1));

    cyc(1, 32'h99999999, 5'd2, 1, 1, 1, 1, 6'b000000, 0, 0);
    cyc(0, 32'h99999999, 5'd2, 1, 1, 1, 1, 6'b000100, 1, 0);
    check("rst_mid_bubble", 64'(pipe_bubble), 64'd0);
    check("rst_mid_payload", 64'(pipe_payload), 64'h0);
    cyc(1, 32'hA5A5A5A5, 5'd31, 1, 1, 1, 0, 6'b000000, 0, 0);
    check("final_load", 64'(pipe_payload), 64'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
